cd_llc_req_arbiter: RTL

CD_LLC_REQ_ARBITER -- requirements
Module: cd_llc_req_arbiter

---
 rtl/cd_xbar_pkg.sv | 18 +
 rtl/cd_rr_arb8.sv | 53 +++++
 rtl/cd_llc_req_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/cd_xbar_pkg.sv
// Shared crossbar constants and helpers for the LLC request arbiter and its
// round-robin sub-arbiters.
package cd_xbar_pkg;

    localparam int XBAR_N_IN   = 8;   // requesting input ports
    localparam int XBAR_N_OUT  = 4;   // LLC output ports
    localparam int LLC_ID_W    = 2;   // width of a target LLC id
    localparam int XBAR_STAT_W = 16;  // width of one grant counter
    localparam int ARB_W       = 8;   // request lanes of one sub-arbiter
    localparam int SEL_W       = 3;   // width of a winner index

    // Advance an arbitration index by one, wrapping at n-1 back to 0.
    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] idx,
                                                  input int               n);
        return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/cd_rr_arb8.sv
// Eight-lane round-robin arbiter. The pointer names the lane with highest
// priority; it moves past the winner only on a cycle where the grant fires.
module cd_rr_arb8
    import cd_xbar_pkg::*;
#(
    parameter int N_REQ = ARB_W   // active lanes, 1..8; lanes above are ignored
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ARB_W-1:0] req,
    input  logic             advance,
    output logic [ARB_W-1:0] grant,
    output logic [SEL_W-1:0] grant_idx,
    output logic             any_req
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] pos;
    logic             found;

    // Scan lanes starting at the pointer and pick the first one requesting.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (which would infer a latch).
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = '0;
        for (int k = 0; k < ARB_W; k++) begin
            if (k < N_REQ) begin
                pos = SEL_W'((int'(ptr) + k) % N_REQ);
                if (!found && req[pos]) begin
                    found     = 1'b1;
                    grant_idx = pos;
                end
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
        any_req = found;
    end

    // Move the pointer one past the winner when the grant is consumed.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= wrap_inc(grant_idx, N_REQ);
        end
    end

endmodule

// File: rtl/cd_llc_req_arbiter.sv
// Routes N_IN request ports onto N_OUT LLC ports. Each LLC has its own
// round-robin arbiter; a grant fires in the same cycle the LLC is ready and
// enabled. Optional per-LLC grant counters are built only when the macro
// CD_LLC_ARB_STATS_EN is defined; otherwise stat_cnt reads as zero.
module cd_llc_req_arbiter
    import cd_xbar_pkg::*;
#(
    parameter int N_IN   = XBAR_N_IN,
    parameter int N_OUT  = XBAR_N_OUT,
    parameter int STAT_W = XBAR_STAT_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_IN-1:0]           in_si,
    input  logic [N_IN*LLC_ID_W-1:0]  in_dst,
    input  logic [N_OUT-1:0]          llc_ro,
    input  logic                      cfg_we,
    input  logic [N_OUT-1:0]          cfg_wdata,
    input  logic                      stat_clr,
    output logic [N_IN-1:0]           in_ri,
    output logic [N_OUT-1:0]          llc_so,
    output logic [N_OUT*SEL_W-1:0]    llc_sel,
    output logic [N_OUT-1:0]          llc_en,
    output logic [N_OUT*STAT_W-1:0]   stat_cnt
);

    logic [N_OUT-1:0][ARB_W-1:0] req_by_llc;
    logic [N_OUT-1:0][ARB_W-1:0] grant;
    logic [N_OUT-1:0][SEL_W-1:0] grant_idx;
    logic [N_OUT-1:0]            any_req;
    logic [N_OUT-1:0]            fire;

    // Decode each input's target id into a request on exactly one LLC.
    always_comb begin
        req_by_llc = '0;
        for (int j = 0; j < N_OUT; j++) begin
            for (int i = 0; i < N_IN; i++) begin
                if (in_si[i] && (in_dst[i*LLC_ID_W +: LLC_ID_W] == LLC_ID_W'(j))) begin
                    req_by_llc[j][i] = 1'b1;
                end
            end
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_arb
        cd_rr_arb8 #(
            .N_REQ (N_IN)
        ) u_arb (
            .clk       (clk),
            .reset     (reset),
            .req       (req_by_llc[j]),
            .advance   (fire[j]),
            .grant     (grant[j]),
            .grant_idx (grant_idx[j]),
            .any_req   (any_req[j])
        );
    end

    // A grant fires only when the LLC is ready, enabled and not in reset.
    assign fire   = any_req & llc_ro & llc_en & {N_OUT{reset}};
    assign llc_so = fire;

    // Accept each winning input and publish winner indices for fired LLCs.
    always_comb begin
        in_ri   = '0;
        llc_sel = '0;
        for (int j = 0; j < N_OUT; j++) begin
            if (fire[j]) begin
                in_ri                   = in_ri | grant[j][N_IN-1:0];
                llc_sel[j*SEL_W +: SEL_W] = grant_idx[j];
            end
        end
    end

    // Enable mask: all LLCs on out of reset, rewritten by the config strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            llc_en <= '1;
        end else if (cfg_we) begin
            llc_en <= cfg_wdata;
        end
    end

`ifdef CD_LLC_ARB_STATS_EN
    logic [N_OUT-1:0][STAT_W-1:0] cnt_q;

    // Saturating per-LLC grant counters; a clear wins over a same-cycle fire.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            for (int j = 0; j < N_OUT; j++) begin
                if (stat_clr) begin
                    cnt_q[j] <= '0;
                end else if (fire[j] && (cnt_q[j] != '1)) begin
                    cnt_q[j] <= cnt_q[j] + 1'b1;
                end
            end
        end
    end

    assign stat_cnt = cnt_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_cnt        = '0;
`endif

endmodule
